cross_bar_decoder_1xn: RTL and testbench
========================================

# cross_bar_decoder_1xn

Packet router for the fan-out side of the MxN cross-bar switch: takes one AXI-Stream input and steers each whole packet to one of `CHANNEL_NO` AXI-Stream outputs, selected by `s_axis_tdest` on the packet's first beat. The route stays locked until `tlast`. Beats pass through a 2-entry output FIFO, so no combinational path exists from any `m_axis_tready` to `s_axis_tready`. Packets addressed to a non-existent channel are consumed and dropped.

## Interface
- `SSEL_WIDTH`, 2, width of destination select
- `CHANNEL_NO`, 2**SSEL_WIDTH, number of output channels (1 < CHANNEL_NO ≤ 2**SSEL_WIDTH)
- `DATA_WIDTH`, 32, tdata width
- `aclk`  in  1  clock; all logic on rising edge
- `areset`  in  1  reset, asynchronous, active-high
- `s_axis_tdata`  in  DATA_WIDTH  input data
- `s_axis_tvalid`  in  1  input valid
- `s_axis_tlast`  in  1  last beat of packet
- `s_axis_tdest`  in  SSEL_WIDTH  destination channel, sampled on the first beat only
- `s_axis_tready`  out  1  input ready; registered-only
- `m_axis_tdata`  out  DATA_WIDTH × [CHANNEL_NO]  output data; every channel carries the FIFO head data
- `m_axis_tvalid`  out  1 × [CHANNEL_NO]  output valid
- `m_axis_tlast`  out  1 × [CHANNEL_NO]  output last; gated by that channel's valid
- `m_axis_tready`  in  1 × [CHANNEL_NO]  output ready
- `drop_pkt`  out  1  one-cycle pulse per dropped packet

## Operation
- Input FSM states:
  - **IDLE**
    - `s_axis_tready`=0.
    - If `s_axis_tvalid`=1 and `s_axis_tdest` < CHANNEL_NO: latch `dest_q` = `s_axis_tdest` and go to **ROUTE**.
    - If `s_axis_tvalid`=1 and `s_axis_tdest` ≥ CHANNEL_NO: go to **DROP**.
    - Otherwise stay in IDLE.
  - **ROUTE**
    - `s_axis_tready` = (count < 2).
    - Each accepted beat pushes {data, last, `dest_q`} into the FIFO.
    - An accepted beat with `tlast`=1 returns the FSM to IDLE.
  - **DROP**
    - `s_axis_tready`=1; beats are discarded and nothing is pushed.
    - An accepted beat with `tlast`=1 returns the FSM to IDLE and sets `drop_pkt`=1 for the next cycle only.
  - Illegal state: go to IDLE.
- Output FIFO:
  - 2 entries, with a count register holding 0..2.
  - Each entry carries its own destination. Beats of consecutive packets bound for different channels may coexist in the FIFO.
  - Head entry drives all channels:
    - `m_axis_tvalid[i]` = (count > 0) && (head_dest == i)
    - `m_axis_tlast[i]` = `m_axis_tvalid[i]` && head_last
    - `m_axis_tdata[i]` = head_data
  - Pop occurs when `m_axis_tvalid[head_dest]` && `m_axis_tready[head_dest]`.
  - Count update:
    - push and no pop: +1
    - pop and no push: −1
    - push and pop together: unchanged
  - Push at count=2 is impossible because `s_axis_tready`=0.
- AXI-Stream rules on outputs:
  - Once valid is asserted, valid, data, last and destination stay stable until the pop.
  - Valid never depends combinationally on `m_axis_tready`.
- `s_axis_tready` is derived only from state and count registers.
- Head-of-line blocking is intended: a stalled channel stalls the whole block.

## Timing
- Reset values while `areset`=1 and on the first edge after release:
  - state IDLE, count 0, FIFO pointers 0
  - `s_axis_tready`=0, `drop_pkt`=0
  - all `m_axis_tvalid`=0, all `m_axis_tlast`=0, `m_axis_tdata`=0
- Reset asserted mid-packet: FIFO contents and in-flight packet are discarded immediately (asynchronous). After release the block waits in IDLE for a new first beat.
- Routing decision: 1 cycle in IDLE per packet. The first beat of a packet is accepted no earlier than the cycle after tvalid is seen in IDLE.
- Latency: beat accepted at edge N is visible on `m_axis` in cycle N+1 when the FIFO was empty.
- Throughput:
  - 1 beat/cycle within a packet when the downstream channel is ready.
  - A packet of L beats occupies the input for L+1 cycles.
- Backpressure: when the downstream channel deasserts ready, the FIFO fills to 2 and `s_axis_tready` falls at the edge where count reaches 2.
- `drop_pkt` is asserted exactly one cycle, in the cycle after the dropped tlast is accepted.

## Test plan
- **Reset values:** hold `areset` 3 cycles with `s_axis_tvalid`=1 -> all `m_axis_tvalid`=0, `s_axis_tready`=0, `drop_pkt`=0. After release, first beat is accepted no earlier than cycle 2.
- **Single packet:** 4-beat packet 0xA0..0xA3 to tdest=2, all readies 1 -> only `m_axis_tvalid[2]` asserts; the 4 beats appear on consecutive cycles; `m_axis_tlast[2]`=1 on 0xA3 only.
- **Back-to-back packets:** 2-beat packet to ch1 followed immediately by a 3-beat packet to ch3 -> exactly one idle input cycle between packets; no beat appears on ch0 or ch2; order preserved.
- **Backpressure:** 5-beat packet to ch0 with `m_axis_tready[0]`=0 for 6 cycles -> `s_axis_tready` drops after 2 beats are accepted; beats resume in order after ready returns; no loss or duplication.
- **Drop:** with CHANNEL_NO=3 and SSEL_WIDTH=2, send a 3-beat packet with tdest=3 -> no `m_axis_tvalid` asserts; `drop_pkt` pulses 1 cycle after the tlast handshake; the next packet to ch0 routes normally.
- **Reset mid-packet:** assert `areset` after 2 of 4 beats with the FIFO non-empty -> outputs clear immediately; after release, a new packet to ch1 routes correctly and no residual beats appear.

Source files
------------

// File: rtl/cross_bar_decoder_1xn_if.sv
// AXI-Stream bundle for the 1xN packet router: one input stream and CHANNEL_NO
// output streams. The router uses the slave view; the traffic source/sink uses master.
interface cross_bar_decoder_1xn_if #(
  parameter int SSEL_WIDTH = 2,
  parameter int CHANNEL_NO = 2**SSEL_WIDTH,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]                  s_axis_tdata;
  logic                                   s_axis_tvalid;
  logic                                   s_axis_tlast;
  logic [SSEL_WIDTH-1:0]                  s_axis_tdest;
  logic                                   s_axis_tready;
  logic [CHANNEL_NO-1:0][DATA_WIDTH-1:0]  m_axis_tdata;
  logic [CHANNEL_NO-1:0]                  m_axis_tvalid;
  logic [CHANNEL_NO-1:0]                  m_axis_tlast;
  logic [CHANNEL_NO-1:0]                  m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tdest,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tdest,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/cross_bar_decoder_1xn.sv
// Fan-out packet router: steers whole AXI-Stream packets to one of CHANNEL_NO outputs
// through a 2-entry FIFO; packets to a non-existent channel are swallowed and flagged.
module cross_bar_decoder_1xn #(
  parameter int SSEL_WIDTH = 2,
  parameter int CHANNEL_NO = 2**SSEL_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  cross_bar_decoder_1xn_if.slave  axis,
  output logic                    drop_pkt
);

  localparam logic [SSEL_WIDTH:0] CH_LIMIT = (SSEL_WIDTH+1)'(CHANNEL_NO);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t                                state_q, state_d;
  logic [SSEL_WIDTH-1:0]                 dest_q, dest_d;
  logic [1:0]                            count_q, count_d;
  logic                                  wr_ptr_q, wr_ptr_d;
  logic                                  rd_ptr_q, rd_ptr_d;
  logic [1:0][DATA_WIDTH-1:0]            mem_data_q, mem_data_d;
  logic [1:0]                            mem_last_q, mem_last_d;
  logic [1:0][SSEL_WIDTH-1:0]            mem_dest_q, mem_dest_d;
  logic                                  tready_q, tready_d;
  logic                                  drop_q, drop_d;
  logic [CHANNEL_NO-1:0]                 tvalid_q, tvalid_d;
  logic [CHANNEL_NO-1:0]                 tlast_q, tlast_d;
  logic [CHANNEL_NO-1:0][DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                                  s_hs_s;
  logic                                  push_s;
  logic                                  pop_s;

  // Input FSM, FIFO bookkeeping, and next values of every registered output.
  // Outputs are registered copies of the head entry computed from next-state values,
  // so they equal the head decode of the current registers without any ready path.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    drop_d     = 1'b0;
    push_s     = 1'b0;
    s_hs_s     = axis.s_axis_tvalid && tready_q;
    pop_s      = (count_q != 2'd0) && (|(tvalid_q & axis.m_axis_tready));
    mem_data_d = mem_data_q;
    mem_last_d = mem_last_q;
    mem_dest_d = mem_dest_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        if (axis.s_axis_tvalid) begin
          if ({1'b0, axis.s_axis_tdest} < CH_LIMIT) begin
            dest_d  = axis.s_axis_tdest;
            state_d = ST_ROUTE;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROUTE: begin
        if (s_hs_s) begin
          push_s = 1'b1;
          if (axis.s_axis_tlast) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ROUTE;
          end
        end else begin
          state_d = ST_ROUTE;
        end
      end
      ST_DROP: begin
        if (s_hs_s && axis.s_axis_tlast) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_s) begin
      mem_data_d[wr_ptr_q] = axis.s_axis_tdata;
      mem_last_d[wr_ptr_q] = axis.s_axis_tlast;
      mem_dest_d[wr_ptr_q] = dest_q;
    end else begin
      mem_data_d = mem_data_q;
    end

    wr_ptr_d = wr_ptr_q ^ push_s;
    rd_ptr_d = rd_ptr_q ^ pop_s;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    tready_d = ((state_d == ST_ROUTE) && (count_d != 2'd2)) || (state_d == ST_DROP);

    for (int i = 0; i < CHANNEL_NO; i++) begin
      tvalid_d[i] = (count_d != 2'd0) && (mem_dest_d[rd_ptr_d] == SSEL_WIDTH'(i));
      tlast_d[i]  = tvalid_d[i] && mem_last_d[rd_ptr_d];
      tdata_d[i]  = mem_data_d[rd_ptr_d];
    end
  end

  // State, FIFO storage and output registers; reset flushes any in-flight packet.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      dest_q     <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_data_q <= '0;
      mem_last_q <= 2'b00;
      mem_dest_q <= '0;
      tready_q   <= 1'b0;
      drop_q     <= 1'b0;
      tvalid_q   <= '0;
      tlast_q    <= '0;
      tdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_data_q <= mem_data_d;
      mem_last_q <= mem_last_d;
      mem_dest_q <= mem_dest_d;
      tready_q   <= tready_d;
      drop_q     <= drop_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
    end
  end

  assign axis.s_axis_tready = tready_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tlast  = tlast_q;
  assign axis.m_axis_tdata  = tdata_q;
  assign drop_pkt           = drop_q;

endmodule

// File: tb/tb_cross_bar_decoder_1xn.sv
// Directed bench for the 1xN router: a 4-channel instance for routing, backpressure and
// reset, and a 3-channel instance for the drop path.
module tb_cross_bar_decoder_1xn;
  localparam int SW = 2;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset;
  logic drop4;
  logic drop3;
  int   total = 0;
  int   bad   = 0;

  cross_bar_decoder_1xn_if #(.SSEL_WIDTH(SW), .CHANNEL_NO(4), .DATA_WIDTH(DW)) if4 ();
  cross_bar_decoder_1xn_if #(.SSEL_WIDTH(SW), .CHANNEL_NO(3), .DATA_WIDTH(DW)) if3 ();

  cross_bar_decoder_1xn #(.SSEL_WIDTH(SW), .CHANNEL_NO(4), .DATA_WIDTH(DW)) dut4 (
    .aclk     (aclk),
    .areset   (areset),
    .axis     (if4.slave),
    .drop_pkt (drop4)
  );

  cross_bar_decoder_1xn #(.SSEL_WIDTH(SW), .CHANNEL_NO(3), .DATA_WIDTH(DW)) dut3 (
    .aclk     (aclk),
    .areset   (areset),
    .axis     (if3.slave),
    .drop_pkt (drop3)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        v;
    logic        l;
    logic [1:0]  d;
    logic [31:0] dat;
    logic [3:0]  rdy;
    logic        e_rdy;
    logic [3:0]  e_v;
    logic [3:0]  e_l;
    logic [31:0] e_dat;
    logic        e_drop;
  } vec_t;

  vec_t q_main[$];
  vec_t q_post[$];
  vec_t q_drop[$];

  function automatic vec_t mk(input logic v, input logic l, input logic [1:0] d,
                              input logic [31:0] dat, input logic [3:0] rdy,
                              input logic e_rdy, input logic [3:0] e_v,
                              input logic [3:0] e_l, input logic [31:0] e_dat,
                              input logic e_drop);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.dat = dat; t.rdy = rdy;
    t.e_rdy = e_rdy; t.e_v = e_v; t.e_l = e_l; t.e_dat = e_dat; t.e_drop = e_drop;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, check the outputs visible this cycle, then advance one clock.
  task automatic run_vec(input vec_t t, input bit on3, input string tag, input int idx);
    logic        a_rdy;
    logic        a_drop;
    logic [3:0]  a_v;
    logic [3:0]  a_l;
    logic [31:0] a_dat;
    if (on3) begin
      if3.s_axis_tvalid = t.v;  if3.s_axis_tlast = t.l;
      if3.s_axis_tdest  = t.d;  if3.s_axis_tdata = t.dat;
      if3.m_axis_tready = t.rdy[2:0];
      a_rdy  = if3.s_axis_tready;
      a_drop = drop3;
      a_v    = {1'b0, if3.m_axis_tvalid};
      a_l    = {1'b0, if3.m_axis_tlast};
      a_dat  = if3.m_axis_tdata[0];
      for (int j = 0; j < 3; j++) if (if3.m_axis_tdata[j] !== t.e_dat) a_dat = if3.m_axis_tdata[j];
    end else begin
      if4.s_axis_tvalid = t.v;  if4.s_axis_tlast = t.l;
      if4.s_axis_tdest  = t.d;  if4.s_axis_tdata = t.dat;
      if4.m_axis_tready = t.rdy;
      a_rdy  = if4.s_axis_tready;
      a_drop = drop4;
      a_v    = if4.m_axis_tvalid;
      a_l    = if4.m_axis_tlast;
      a_dat  = if4.m_axis_tdata[0];
      for (int j = 0; j < 4; j++) if (if4.m_axis_tdata[j] !== t.e_dat) a_dat = if4.m_axis_tdata[j];
    end
    chk($sformatf("%s[%0d] s_tready", tag, idx), {127'd0, a_rdy}, {127'd0, t.e_rdy});
    chk($sformatf("%s[%0d] m_tvalid", tag, idx), {124'd0, a_v}, {124'd0, t.e_v});
    chk($sformatf("%s[%0d] m_tlast", tag, idx), {124'd0, a_l}, {124'd0, t.e_l});
    chk($sformatf("%s[%0d] drop_pkt", tag, idx), {127'd0, a_drop}, {127'd0, t.e_drop});
    if (t.e_v != 4'd0) chk($sformatf("%s[%0d] m_tdata", tag, idx), {96'd0, a_dat}, {96'd0, t.e_dat});
    @(posedge aclk);
    #1;
  endtask

  initial begin
    // single packet to ch2, ready everywhere
    q_main.push_back(mk(1'b1, 1'b0, 2'd2, 32'hA0, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd2, 32'hA0, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd2, 32'hA1, 4'hF, 1'b1, 4'h4, 4'h0, 32'hA0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd2, 32'hA2, 4'hF, 1'b1, 4'h4, 4'h0, 32'hA1, 1'b0));
    q_main.push_back(mk(1'b1, 1'b1, 2'd2, 32'hA3, 4'hF, 1'b1, 4'h4, 4'h0, 32'hA2, 1'b0));
    q_main.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h4, 4'h4, 32'hA3, 1'b0));
    q_main.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    // back-to-back: 2 beats to ch1, then 3 beats to ch3
    q_main.push_back(mk(1'b1, 1'b0, 2'd1, 32'hB0, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd1, 32'hB0, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b1, 2'd1, 32'hB1, 4'hF, 1'b1, 4'h2, 4'h0, 32'hB0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd3, 32'hC0, 4'hF, 1'b0, 4'h2, 4'h2, 32'hB1, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd3, 32'hC0, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd3, 32'hC1, 4'hF, 1'b1, 4'h8, 4'h0, 32'hC0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b1, 2'd3, 32'hC2, 4'hF, 1'b1, 4'h8, 4'h0, 32'hC1, 1'b0));
    q_main.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h8, 4'h8, 32'hC2, 1'b0));
    q_main.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    // backpressure: 5 beats to ch0, ch0 not ready for 6 cycles
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD0, 4'hE, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD0, 4'hE, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD1, 4'hE, 1'b1, 4'h1, 4'h0, 32'hD0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD2, 4'hE, 1'b0, 4'h1, 4'h0, 32'hD0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD2, 4'hE, 1'b0, 4'h1, 4'h0, 32'hD0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD2, 4'hE, 1'b0, 4'h1, 4'h0, 32'hD0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD2, 4'hF, 1'b0, 4'h1, 4'h0, 32'hD0, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD2, 4'hF, 1'b1, 4'h1, 4'h0, 32'hD1, 1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd0, 32'hD3, 4'hF, 1'b1, 4'h1, 4'h0, 32'hD2, 1'b0));
    q_main.push_back(mk(1'b1, 1'b1, 2'd0, 32'hD4, 4'hF, 1'b1, 4'h1, 4'h0, 32'hD3, 1'b0));
    q_main.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h1, 4'h1, 32'hD4, 1'b0));
    q_main.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    // lead-in for mid-packet reset: 2 beats to stalled ch2
    q_main.push_back(mk(1'b1, 1'b0, 2'd2, 32'hE0, 4'hB, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd2, 32'hE0, 4'hB, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_main.push_back(mk(1'b1, 1'b0, 2'd2, 32'hE1, 4'hB, 1'b1, 4'h4, 4'h0, 32'hE0, 1'b0));
    // after reset: fresh 2-beat packet to ch1, nothing left over
    q_post.push_back(mk(1'b1, 1'b0, 2'd1, 32'hF0, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    q_post.push_back(mk(1'b1, 1'b0, 2'd1, 32'hF0, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_post.push_back(mk(1'b1, 1'b1, 2'd1, 32'hF1, 4'hF, 1'b1, 4'h2, 4'h0, 32'hF0, 1'b0));
    q_post.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h2, 4'h2, 32'hF1, 1'b0));
    q_post.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    q_post.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    // 3-channel instance: packet to tdest=3 is dropped, next packet to ch0 routes
    q_drop.push_back(mk(1'b1, 1'b0, 2'd3, 32'h70, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));
    q_drop.push_back(mk(1'b1, 1'b0, 2'd3, 32'h70, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_drop.push_back(mk(1'b1, 1'b0, 2'd3, 32'h71, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_drop.push_back(mk(1'b1, 1'b1, 2'd3, 32'h72, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_drop.push_back(mk(1'b1, 1'b1, 2'd0, 32'h80, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b1));
    q_drop.push_back(mk(1'b1, 1'b1, 2'd0, 32'h80, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,  1'b0));
    q_drop.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h1, 4'h1, 32'h80, 1'b0));
    q_drop.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 4'h0, 4'h0, 32'h0,  1'b0));

    areset = 1'b1;
    if4.s_axis_tvalid = 1'b1; if4.s_axis_tlast = 1'b0;
    if4.s_axis_tdest  = 2'd2; if4.s_axis_tdata = 32'hA0;
    if4.m_axis_tready = 4'hF;
    if3.s_axis_tvalid = 1'b0; if3.s_axis_tlast = 1'b0;
    if3.s_axis_tdest  = 2'd0; if3.s_axis_tdata = 32'h0;
    if3.m_axis_tready = 3'b111;

    // reset held 3 cycles with tvalid high: everything stays cleared
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk);
      #1;
      chk($sformatf("reset[%0d] s_tready", c), {127'd0, if4.s_axis_tready}, 128'd0);
      chk($sformatf("reset[%0d] m_tvalid", c), {124'd0, if4.m_axis_tvalid}, 128'd0);
      chk($sformatf("reset[%0d] m_tlast", c), {124'd0, if4.m_axis_tlast}, 128'd0);
      chk($sformatf("reset[%0d] m_tdata", c), if4.m_axis_tdata, 128'd0);
      chk($sformatf("reset[%0d] drop_pkt", c), {127'd0, drop4}, 128'd0);
      chk($sformatf("reset[%0d] dut3 m_tvalid", c), {125'd0, if3.m_axis_tvalid}, 128'd0);
    end
    areset = 1'b0;

    for (int k = 0; k < q_main.size(); k++) run_vec(q_main[k], 1'b0, "main", k);

    // FIFO holds E0,E1 with ch2 stalled; reset mid-packet must clear outputs at once
    chk("prereset m_tvalid", {124'd0, if4.m_axis_tvalid}, {124'd0, 4'h4});
    chk("prereset m_tdata2", {96'd0, if4.m_axis_tdata[2]}, {96'd0, 32'hE0});
    #2;
    areset = 1'b1;
    if4.s_axis_tvalid = 1'b0;
    #1;
    chk("midreset m_tvalid", {124'd0, if4.m_axis_tvalid}, 128'd0);
    chk("midreset m_tlast", {124'd0, if4.m_axis_tlast}, 128'd0);
    chk("midreset m_tdata", if4.m_axis_tdata, 128'd0);
    chk("midreset s_tready", {127'd0, if4.s_axis_tready}, 128'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    for (int k = 0; k < q_post.size(); k++) run_vec(q_post[k], 1'b0, "post", k);
    for (int k = 0; k < q_drop.size(); k++) run_vec(q_drop[k], 1'b1, "drop", k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
